// File: rtl/mux3_rr_arbiter.sv
// mux3_rr_arbiter: round-robin arbiter for three valid/ready requesters with a shared mux and a registered output.
// Define MUX3_ARB_HOLD_LIMIT_EN to force a grant release after MAX_HOLD accepted beats.
module mux3_rr_arbiter #(
   parameter int size     = 32,
   parameter int MAX_HOLD = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            valid0_i,
   input  logic            valid1_i,
   input  logic            valid2_i,
   input  logic [size-1:0] data0_i,
   input  logic [size-1:0] data1_i,
   input  logic [size-1:0] data2_i,
   output logic            ready0_o,
   output logic            ready1_o,
   output logic            ready2_o,
   output logic [size-1:0] data_o,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [1:0]      select_o,
   output logic            busy_o
);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t          state_q, state_d;
   logic [1:0]      sel_q, sel_d, last_q, last_d, n1, n2, pick;
   logic            valid_q, valid_d, vsel, accept, hold_done;
   logic [size-1:0] data_q, data_d, mux_data;
   logic [2:0]      v;
   function automatic logic vbit(input logic [2:0] vec, input logic [1:0] i);
      return i == 2'd0 ? vec[0] : i == 2'd1 ? vec[1] : vec[2];
   endfunction
   function automatic logic [1:0] inc3(input logic [1:0] i);
      return i == 2'd2 ? 2'd0 : i + 2'd1;
   endfunction
   assign v        = {valid2_i, valid1_i, valid0_i};
   assign vsel     = vbit(v, sel_q);
   assign accept   = state_q == GRANT && vsel && (!valid_q || ready_i);
   assign mux_data = sel_q == 2'd0 ? data0_i : sel_q == 2'd1 ? data1_i : data2_i;
   // scan order after the last holder: last+1, last+2, then last itself
   assign n1       = inc3(last_q);
   assign n2       = inc3(n1);
   assign pick     = vbit(v, n1) ? n1 : vbit(v, n2) ? n2 : last_q;
   assign ready0_o = accept && sel_q == 2'd0;
   assign ready1_o = accept && sel_q == 2'd1;
   assign ready2_o = accept && sel_q == 2'd2;
   assign data_o   = data_q;
   assign valid_o  = valid_q;
   assign select_o = sel_q;
   assign busy_o   = state_q == GRANT;
`ifdef MUX3_ARB_HOLD_LIMIT_EN
   logic [3:0] cnt_q, cnt_d;
   assign hold_done = accept && (cnt_q + 4'd1 == 4'(MAX_HOLD));
   always_comb begin
      cnt_d = state_q == IDLE ? 4'd0 : cnt_q + {3'd0, accept};
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= 4'd0;
      else       cnt_q <= cnt_d;
   end
`else
   logic [3:0] unused_hold;
   assign unused_hold = 4'(MAX_HOLD);
   assign hold_done   = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      last_d  = last_q;
      valid_d = accept ? 1'b1 : ready_i ? 1'b0 : valid_q;
      data_d  = accept ? mux_data : data_q;
      if (state_q == IDLE) begin
         if (|v) begin
            sel_d   = pick;
            state_d = GRANT;
         end
      end else if (!vsel || hold_done) begin
         last_d  = sel_q;
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         sel_q   <= 2'd0;
         last_q  <= 2'd2;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end
endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// tb_mux3_rr_arbiter: scoreboard bench with a cycle-level reference model of the grant rules.
module tb_mux3_rr_arbiter;
   localparam int W  = 32;
   localparam int MH = 2;
`ifdef MUX3_ARB_HOLD_LIMIT_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif
   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic [2:0]    vin = 3'b000;
   logic [W-1:0]  din [3];
   logic          rdy = 1'b0;
   logic          ready0_o, ready1_o, ready2_o, valid_o, busy_o;
   logic [W-1:0]  data_o;
   logic [1:0]    select_o;
   int            checks = 0;
   int            errors = 0;
   int            g = -1;
   int            last = 2;
   int            sel = 0;
   int            beats = 0;
   bit            ov = 1'b0;
   logic [W-1:0]  q [$];

   mux3_rr_arbiter #(.size(W), .MAX_HOLD(MH)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .valid0_i(vin[0]), .valid1_i(vin[1]), .valid2_i(vin[2]),
      .data0_i(din[0]), .data1_i(din[1]), .data2_i(din[2]),
      .ready0_o(ready0_o), .ready1_o(ready1_o), .ready2_o(ready2_o),
      .data_o(data_o), .valid_o(valid_o), .ready_i(rdy),
      .select_o(select_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"}, {29'd0, ready2_o, ready1_o, ready0_o}, 0);
      chk({tag, "_valid_o"}, valid_o, 0);
      chk({tag, "_data_o"}, data_o, 0);
      chk({tag, "_select"}, select_o, 0);
      chk({tag, "_busy"}, busy_o, 0);
   endtask

   // one cycle: drive inputs, check combinational and registered outputs, advance the model
   task automatic cycle(input logic [2:0] vv, input logic r, input logic [W-1:0] d0, input logic [W-1:0] d1, input logic [W-1:0] d2);
      bit acc, found;
      @(negedge clk_i);
      vin = vv; rdy = r; din[0] = d0; din[1] = d1; din[2] = d2;
      #1;
      acc = g >= 0 && vv[g] && (!ov || r);
      chk("ready", {29'd0, ready2_o, ready1_o, ready0_o}, acc ? (32'd1 << g) : 32'd0);
      chk("select", select_o, sel);
      chk("busy", busy_o, g >= 0);
      chk("valid_o", valid_o, ov);
      if (acc) begin
         q.push_back(din[g]);
         ov = 1'b1;
         beats++;
      end else if (r) ov = 1'b0;
      if (g < 0) begin
         found = 1'b0;
         for (int k = 1; k <= 3; k++) begin
            if (!found && vv[(last + k) % 3]) begin
               found = 1'b1;
               g = (last + k) % 3;
               sel = g;
               beats = 0;
            end
         end
      end else if (!vv[g] || (HOLD && acc && beats == MH)) begin
         last = g;
         g = -1;
      end
   endtask

   task automatic rcycle();
      logic [2:0] vv;
      vv = {$urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0};
      cycle(vv, $urandom_range(0, 3) != 0, $urandom, $urandom, $urandom);
   endtask

   // scoreboard monitor: a transfer on the output pops the oldest accepted word
   initial forever begin
      @(negedge clk_i);
      #2;
      if (!rst_i && valid_o && rdy) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL data_o: got unexpected beat %h expected none", data_o);
         end else chk("data_o", data_o, q.pop_front());
      end
   end

   initial begin
      din[0] = '0; din[1] = '0; din[2] = '0;
      #1;
      chk_reset_outputs("reset");
      @(negedge clk_i);
      rst_i = 1'b0;
      // single request from requester 1
      cycle(3'b010, 1'b1, 32'h0, 32'hA5A5A5A5, 32'h0);
      cycle(3'b010, 1'b1, 32'h0, 32'hA5A5A5A5, 32'h0);
      cycle(3'b000, 1'b1, 32'h0, 32'h0, 32'h0);
      chk("single_data", data_o, 32'hA5A5A5A5);
      cycle(3'b000, 1'b1, 32'h0, 32'h0, 32'h0);
      cycle(3'b000, 1'b1, 32'h0, 32'h0, 32'h0);
      // backpressure while requester 0 is granted
      for (int i = 0; i < 9; i++)
         cycle(3'b001, (i >= 2 && i <= 4) ? 1'b0 : 1'b1, 32'h100 + i, 32'h0, 32'h0);
      cycle(3'b000, 1'b1, 32'h0, 32'h0, 32'h0);
      cycle(3'b000, 1'b1, 32'h0, 32'h0, 32'h0);
      // all requesters continuously valid
      for (int i = 0; i < 16; i++)
         cycle(3'b111, 1'b1, 32'h200 + i, 32'h300 + i, 32'h400 + i);
      // requester 0 drops, remaining two continue
      for (int i = 0; i < 6; i++)
         cycle(3'b110, 1'b1, 32'h0, 32'h500 + i, 32'h600 + i);
      cycle(3'b000, 1'b1, 32'h0, 32'h0, 32'h0);
      cycle(3'b000, 1'b1, 32'h0, 32'h0, 32'h0);
      // reset mid-burst with a held output beat
      for (int i = 0; i < 3; i++)
         cycle(3'b001, 1'b0, 32'h700 + i, 32'h0, 32'h0);
      chk("held_valid", valid_o, 1);
      @(negedge clk_i);
      #3;
      rst_i = 1'b1;
      vin = 3'b000;
      #1;
      chk_reset_outputs("mid_reset");
      g = -1; last = 2; sel = 0; beats = 0; ov = 1'b0;
      q.delete();
      @(negedge clk_i);
      rst_i = 1'b0;
      cycle(3'b111, 1'b1, 32'h800, 32'h900, 32'hA00);
      cycle(3'b111, 1'b1, 32'h801, 32'h901, 32'hA01);
      chk("restart_sel", select_o, 0);
      // randomized traffic
      for (int i = 0; i < 3000; i++) rcycle();
      for (int i = 0; i < 4; i++) cycle(3'b000, 1'b1, 32'h0, 32'h0, 32'h0);
      chk("leftover", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
